stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: WIDTH, 8, data bits per word.
REQ-002 Parameter: CH, 8, output channel count; legal range 2..16.
REQ-003 Parameter: SELW, 3, select width; SHALL satisfy 2**SELW >= CH.
REQ-004 Port: Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: Rst  input  1  reset, synchronous, active-high.
REQ-006 Port: E  input  1  enable; 0 blocks new input acceptance.
REQ-007 Port: Sel  input  SELW  destination channel of the current input word.
REQ-008 Port: In  input  WIDTH  input data word.
REQ-009 Port: InValid  input  1  In/Sel valid this cycle.
REQ-010 Port: InReady  output  1  block accepts In this cycle.
REQ-011 Port: Out  output  CH*WIDTH  channel k data on bits [k*WIDTH +: WIDTH].
REQ-012 Port: OutValid  output  CH  bit k = channel k holds an undelivered word.
REQ-013 Port: OutReady  input  CH  bit k = channel k consumer accepts this cycle.
REQ-014 Port: DropCnt  output  8  out-of-range drop count; present only with DEMUX_DROP_EN.

Function
REQ-015 Each channel SHALL have one WIDTH-bit holding register plus one valid flag.
REQ-016 Input transfer = InValid & InReady; output transfer on channel k = OutValid[k] & OutReady[k].
REQ-017 InReady SHALL be combinational: E & (~OutValid[d] | OutReady[d]), d = resolved destination channel.
REQ-018 On input transfer, In SHALL be written to channel d; OutValid[d] = 1 from the next cycle (latency 1).
REQ-019 Only channel d is written; all other channels' data and valid are unchanged.
REQ-020 Output transfer with no write to the same channel SHALL clear OutValid[k] next cycle; Out data bits keep their last value.
REQ-021 Same-cycle output transfer and input write on one channel SHALL leave OutValid[k] = 1 with the new word (full throughput).
REQ-022 E = 0 SHALL force InReady = 0; held words stay and continue draining via OutReady.
REQ-023 InValid = 0 SHALL cause no write, whatever Sel and E are.
REQ-024 Sel < CH SHALL select channel Sel directly.
REQ-025 Ordering within a channel SHALL be preserved; no word is overwritten while OutValid = 1 and OutReady = 0.

Reset
REQ-026 Rst = 1 at a clock edge SHALL clear all OutValid bits, all Out data to 0, and DropCnt to 0.
REQ-027 While Rst = 1, InReady SHALL be 0.
REQ-028 Reset mid-operation SHALL discard all held words; nothing is output after reset until a new input transfer.

Configuration
REQ-029 Macro DEMUX_DROP_EN defined: Sel >= CH SHALL give InReady = E, the word is discarded, and DropCnt increments by 1, saturating at 255.
REQ-030 DEMUX_DROP_EN undefined: Sel >= CH SHALL resolve to channel CH-1 with normal handshake; DropCnt port absent.

Verification (CH=8, WIDTH=8 unless noted)
REQ-031 Reset, then E=1, InValid=1, Sel=3, In=0xA5 for one cycle, OutReady=0 -> next cycle OutValid=0x08, channel 3 data = 0xA5, other channels 0.
REQ-032 Channel 3 full with OutReady[3]=0, second word 0x5A to Sel=3 -> InReady=0, channel 3 keeps 0xA5; set OutReady[3]=1 -> 0x5A accepted the same cycle and appears next cycle, OutValid[3] stays 1.
REQ-033 E=0, InValid=1, Sel=0, In=0x11 -> InReady=0 and OutValid[0] stays 0; a word already held in channel 2 drains when OutReady[2]=1.
REQ-034 CH=6, Sel=7, In=0x77, 300 consecutive valid cycles -> with DEMUX_DROP_EN: InReady=1, OutValid=0, DropCnt=255; without: channel 5 receives 0x77, one word per cycle while OutReady[5]=1.
REQ-035 Rst=1 asserted while OutValid=0xFF -> next cycle OutValid=0x00, all Out=0, DropCnt=0, InReady=0 during reset.
REQ-036 Words 0x01..0x08 sent back-to-back to channels 0..7, all OutReady=1 -> each OutValid[k] pulses exactly one cycle, one cycle after its input, with the matching data.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: routes a valid/ready input stream to one of CH output channels.
// Each channel owns one WIDTH-bit holding register plus a valid flag, so a
// channel can accept a new word in the same cycle its held word is consumed.
//
// Ports
//   Clk       clock, all state updates on rising edge
//   Rst       synchronous active-high reset
//   E         enable; low blocks new input acceptance (held words still drain)
//   Sel       destination channel of the current input word
//   In        input data word
//   InValid   In/Sel valid this cycle
//   InReady   combinational: the block accepts In this cycle
//   Out       channel k data on bits [k*WIDTH +: WIDTH]
//   OutValid  bit k = channel k holds an undelivered word
//   OutReady  bit k = channel k consumer accepts this cycle
//   DropCnt   saturating count of discarded out-of-range words (DEMUX_DROP_EN only)
//
// Configuration macro: DEMUX_DROP_EN
//   defined   : Sel >= CH words are accepted whenever E is high and discarded
//   undefined : Sel >= CH words are steered to channel CH-1
module stream_demux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH    = 8,
    parameter int unsigned SELW  = 3
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  E,
    input  logic [SELW-1:0]       Sel,
    input  logic [WIDTH-1:0]      In,
    input  logic                  InValid,
    output logic                  InReady,
    output logic [CH*WIDTH-1:0]   Out,
    output logic [CH-1:0]         OutValid,
    input  logic [CH-1:0]         OutReady
`ifdef DEMUX_DROP_EN
    ,
    output logic [7:0]            DropCnt
`endif
);

    logic                         in_range_c;
    logic [SELW-1:0]              dest_c;
    logic [CH-1:0]                hit_c;
    logic                         dest_free_c;
    logic                         ready_c;
    logic                         in_xfer_c;

    logic [CH-1:0][WIDTH-1:0]     data_q, data_d;
    logic [CH-1:0]                valid_q, valid_d;

`ifdef DEMUX_DROP_EN
    localparam int unsigned DROPW = 8;
    logic [DROPW-1:0]             drop_q, drop_d;
`endif

    // Destination resolution and input handshake
    always_comb begin
        in_range_c  = (32'(Sel) < CH);
`ifdef DEMUX_DROP_EN
        // Out-of-range selects hit no channel and are discarded.
        dest_c      = Sel;
`else
        dest_c      = in_range_c ? Sel : SELW'(CH - 1);
`endif
        hit_c       = '0;
        dest_free_c = 1'b0;
        for (int unsigned k = 0; k < CH; k++) begin
            hit_c[k] = (dest_c == SELW'(k));
            if (hit_c[k]) begin
                // Free if empty, or if the held word leaves this cycle.
                dest_free_c = ~valid_q[k] | OutReady[k];
            end
        end
`ifdef DEMUX_DROP_EN
        ready_c = ~Rst & E & (in_range_c ? dest_free_c : 1'b1);
`else
        ready_c = ~Rst & E & dest_free_c;
`endif
        in_xfer_c = InValid & ready_c;
    end

    // Channel next-state: drain on output handshake, then overlay the write
    always_comb begin
        valid_d = valid_q & ~OutReady;
        data_d  = data_q;
        for (int unsigned k = 0; k < CH; k++) begin
            if (in_xfer_c && hit_c[k]) begin
                data_d[k]  = In;
                valid_d[k] = 1'b1;
            end
        end
    end

`ifdef DEMUX_DROP_EN
    // Saturating drop counter
    always_comb begin
        drop_d = drop_q;
        if (in_xfer_c && !in_range_c && (drop_q != {DROPW{1'b1}})) begin
            drop_d = drop_q + DROPW'(1);
        end
    end
`endif

    // State registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            data_q  <= '0;
            valid_q <= '0;
`ifdef DEMUX_DROP_EN
            drop_q  <= '0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef DEMUX_DROP_EN
            drop_q  <= drop_d;
`endif
        end
    end

    assign InReady  = ready_c;
    assign Out      = data_q;
    assign OutValid = valid_q;
`ifdef DEMUX_DROP_EN
    assign DropCnt  = drop_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: per-channel queue scoreboard for an
// 8-channel instance, plus a 6-channel instance for out-of-range selects.
module tb_stream_demux;

    logic        Clk;
    logic        Rst;
    logic        E;
    logic [2:0]  Sel;
    logic [7:0]  In;
    logic        InValid;
    logic        InReady;
    logic [63:0] Out;
    logic [7:0]  OutValid;
    logic [7:0]  OutReady;

    logic        rst6;
    logic        e6;
    logic [2:0]  sel6;
    logic [7:0]  in6;
    logic        iv6;
    logic        ready6;
    logic [47:0] out6;
    logic [5:0]  ov6;
    logic [5:0]  ordy6;

`ifdef DEMUX_DROP_EN
    logic [7:0]  DropCnt;
    logic [7:0]  dc6;
`endif

    stream_demux #(.WIDTH(8), .CH(8), .SELW(3)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .E        (E),
        .Sel      (Sel),
        .In       (In),
        .InValid  (InValid),
        .InReady  (InReady),
        .Out      (Out),
        .OutValid (OutValid),
        .OutReady (OutReady)
`ifdef DEMUX_DROP_EN
        ,
        .DropCnt  (DropCnt)
`endif
    );

    stream_demux #(.WIDTH(8), .CH(6), .SELW(3)) dut6 (
        .Clk      (Clk),
        .Rst      (rst6),
        .E        (e6),
        .Sel      (sel6),
        .In       (in6),
        .InValid  (iv6),
        .InReady  (ready6),
        .Out      (out6),
        .OutValid (ov6),
        .OutReady (ordy6)
`ifdef DEMUX_DROP_EN
        ,
        .DropCnt  (dc6)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    // Reference model: words in flight per channel, and last word written.
    logic [7:0] sb [8][$];
    logic [7:0] last_w [8];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    // One bus cycle on the 8-channel instance; inputs change just after posedge.
    task automatic cycle(input bit r, input bit e, input bit iv, input logic [2:0] s,
                         input logic [7:0] d, input logic [7:0] ordy);
        bit exp_rdy;
        bit xfer;
        Rst = r; E = e; InValid = iv; Sel = s; In = d; OutReady = ordy;
        @(negedge Clk);
        exp_rdy = !r && e && ((sb[s].size() == 0) || ordy[s]);
        if (checking) chk("in_ready", 64'(InReady), 64'(exp_rdy));
        xfer = iv && exp_rdy;
        @(posedge Clk);
        if (r) begin
            for (int k = 0; k < 8; k++) begin
                sb[k].delete();
                last_w[k] = 8'h00;
            end
            checking = 1'b1;
        end else if (xfer) begin
            sb[s].push_back(d);
            last_w[s] = d;
        end
        #1;
    endtask

    // Monitor: compare presented outputs, retire words on output handshakes.
    logic [7:0]  exp_v;
    logic [63:0] exp_o;
    logic [7:0]  pop_k;
    always begin
        @(negedge Clk);
        pop_k = '0;
        if (checking) begin
            for (int k = 0; k < 8; k++) begin
                exp_v[k]         = (sb[k].size() != 0);
                exp_o[k*8 +: 8]  = last_w[k];
                if (exp_v[k]) chk("held_word", 64'(Out[k*8 +: 8]), 64'(sb[k][0]));
            end
            chk("out_valid", 64'(OutValid), 64'(exp_v));
            chk("out_data", Out, exp_o);
`ifdef DEMUX_DROP_EN
            chk("drop_cnt_ch8", 64'(DropCnt), 64'(0));
`endif
            pop_k = exp_v & OutReady;
        end
        @(posedge Clk);
        if (!Rst) begin
            for (int k = 0; k < 8; k++) begin
                if (pop_k[k] && sb[k].size() > 0) void'(sb[k].pop_front());
            end
        end
    end

    initial begin
        Rst = 1'b1; E = 1'b0; InValid = 1'b0; Sel = '0; In = '0; OutReady = '0;
        rst6 = 1'b1; e6 = 1'b0; sel6 = '0; in6 = '0; iv6 = 1'b0; ordy6 = '0;
        for (int k = 0; k < 8; k++) last_w[k] = 8'h00;
        #1;
        cycle(1, 0, 0, 3'd0, 8'h00, 8'h00);
        cycle(1, 1, 1, 3'd0, 8'h00, 8'h00);

        // Single word into channel 3
        cycle(0, 1, 1, 3'd3, 8'hA5, 8'h00);
        cycle(0, 1, 0, 3'd0, 8'h00, 8'h00);
        // Back-pressure, then same-cycle drain and refill
        cycle(0, 1, 1, 3'd3, 8'h5A, 8'h00);
        cycle(0, 1, 1, 3'd3, 8'h5A, 8'h08);
        cycle(0, 1, 0, 3'd0, 8'h00, 8'h00);
        cycle(0, 1, 0, 3'd0, 8'h00, 8'h08);
        cycle(0, 1, 0, 3'd0, 8'h00, 8'h00);
        // Enable low blocks input while channel 2 drains
        cycle(0, 1, 1, 3'd2, 8'h22, 8'h00);
        cycle(0, 0, 1, 3'd0, 8'h11, 8'h00);
        cycle(0, 0, 1, 3'd0, 8'h11, 8'h04);
        cycle(0, 0, 1, 3'd0, 8'h11, 8'h00);
        // Back-to-back words to every channel, all consumers ready
        for (int k = 0; k < 8; k++) cycle(0, 1, 1, 3'(k), 8'(k + 1), 8'hFF);
        cycle(0, 1, 0, 3'd0, 8'h00, 8'hFF);
        cycle(0, 1, 0, 3'd0, 8'h00, 8'hFF);
        // Fill all channels, then reset mid-operation
        for (int k = 0; k < 8; k++) cycle(0, 1, 1, 3'(k), 8'(8'hC0 + k), 8'h00);
        cycle(1, 1, 1, 3'd0, 8'h99, 8'h00);
        cycle(0, 1, 0, 3'd0, 8'h00, 8'hFF);
        cycle(0, 1, 0, 3'd0, 8'h00, 8'h00);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) == 0), ($urandom_range(9) != 0), 1'($urandom),
                  3'($urandom), 8'($urandom), 8'($urandom));
        end
        cycle(0, 0, 0, 3'd0, 8'h00, 8'hFF);
        cycle(0, 0, 0, 3'd0, 8'h00, 8'hFF);

        // Out-of-range select on a 6-channel instance
        @(posedge Clk); #1;
        rst6 = 1'b0; e6 = 1'b1; iv6 = 1'b1; sel6 = 3'd7; in6 = 8'h77; ordy6 = 6'h3F;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            chk("ch6_ready", 64'(ready6), 64'(1));
`ifdef DEMUX_DROP_EN
            chk("ch6_valid", 64'(ov6), 64'(0));
            chk("ch6_data", 64'(out6), 64'(0));
            chk("ch6_drop", 64'(dc6), 64'((i > 255) ? 255 : i));
`else
            chk("ch6_valid", 64'(ov6), 64'((i > 0) ? 6'h20 : 6'h00));
            if (i > 0) chk("ch6_data", 64'(out6), {16'h0, 8'h77, 40'h0});
`endif
            @(posedge Clk); #1;
        end
        iv6 = 1'b0;
        @(negedge Clk);
`ifdef DEMUX_DROP_EN
        chk("ch6_drop_final", 64'(dc6), 64'(255));
`else
        chk("ch6_last_word", 64'(out6[47:40]), 64'(8'h77));
`endif
        // Reset on the 6-channel instance clears its state
        @(posedge Clk); #1;
        rst6 = 1'b1;
        @(negedge Clk);
        chk("ch6_ready_in_reset", 64'(ready6), 64'(0));
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("ch6_valid_after_reset", 64'(ov6), 64'(0));
        chk("ch6_data_after_reset", 64'(out6), 64'(0));
`ifdef DEMUX_DROP_EN
        chk("ch6_drop_after_reset", 64'(dc6), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
